// File: rtl/csa_pkg.sv
// csa_pkg: shared state encoding, width helpers and default parameters for the CSA resolve accumulator
package csa_pkg;
    typedef enum logic [1:0] {ACC, RES, OUT} state_t;
    localparam int W_DEF     = 4;
    localparam int E_DEF     = 9;
    localparam int MAXB_DEF  = 16;
    localparam int CHUNK_DEF = 6;
    function automatic int aw_of(input int iw, input int maxb);
        return iw + 1 + $clog2(maxb);
    endfunction
    function automatic int nch_of(input int aw, input int chunk);
        return (aw + chunk - 1) / chunk;
    endfunction
endpackage

// File: rtl/csa_resolve_acc_if.sv
// csa_resolve_acc_if: beat input stream and result output stream of the resolve accumulator
interface csa_resolve_acc_if #(
    parameter int IW = 13,
    parameter int AW = 18
);
    logic          in_valid_i;
    logic          in_ready_o;
    logic [IW-1:0] sum_i;
    logic [IW-1:0] cout_i;
    logic          last_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [AW-1:0] out_data_o;
    logic          err_o;
    modport master (
        output in_valid_i, sum_i, cout_i, last_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_data_o, err_o
    );
    modport slave (
        input  in_valid_i, sum_i, cout_i, last_i, out_ready_i,
        output in_ready_o, out_valid_o, out_data_o, err_o
    );
endinterface

// File: rtl/csa_resolve_acc_compress.sv
// csa_compress_4to2: two full-adder rows folding four AW-bit operands into a sum/carry pair, top carry dropped
module csa_compress_4to2 #(
    parameter int AW = 18
) (
    input  logic [AW-1:0] a,
    input  logic [AW-1:0] b,
    input  logic [AW-1:0] c,
    input  logic [AW-1:0] d,
    output logic [AW-1:0] s,
    output logic [AW-1:0] cy
);
    logic [AW-1:0] s1;
    logic [AW-1:0] c1;
    logic [AW-2:0] m1;
    logic [AW-2:0] m2;
    assign s1 = a ^ b ^ c;
    assign m1 = (a[AW-2:0] & b[AW-2:0]) | (a[AW-2:0] & c[AW-2:0]) | (b[AW-2:0] & c[AW-2:0]);
    assign c1 = {m1, 1'b0};
    assign s  = s1 ^ c1 ^ d;
    assign m2 = (s1[AW-2:0] & c1[AW-2:0]) | (s1[AW-2:0] & d[AW-2:0]) | (c1[AW-2:0] & d[AW-2:0]);
    assign cy = {m2, 1'b0};
endmodule

// File: rtl/csa_resolve_acc.sv
// csa_resolve_acc: carry-save beat accumulator with chunked ripple resolve; CSA_RES_BEATCHK_EN enables the beat-limit check
module csa_resolve_acc
    import csa_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int E     = E_DEF,
    parameter int MAXB  = MAXB_DEF,
    parameter int CHUNK = CHUNK_DEF
) (
    input logic              clk,
    input logic              rst_n,
    csa_resolve_acc_if.slave bus
);
    localparam int IW  = W + E;
    localparam int AW  = aw_of(IW, MAXB);
    localparam int NCH = nch_of(AW, CHUNK);
    localparam int KW  = NCH > 1 ? $clog2(NCH) : 1;
    localparam int PW  = NCH * CHUNK;

    state_t          state;
    state_t          state_nx;
    logic [AW-1:0]   acc_s;
    logic [AW-1:0]   acc_c;
    logic [AW-1:0]   cmp_s;
    logic [AW-1:0]   cmp_c;
    logic [PW-1:0]   acc_s_p;
    logic [PW-1:0]   acc_c_p;
    logic [KW-1:0]   k;
    logic            rc;
    logic [PW-1:0]   res;
    logic [CHUNK:0]  ch_sum;
    logic            fire;
    logic            hs;
    logic            done;
    logic            force_last;
    logic            err;

    assign fire = bus.in_valid_i & bus.in_ready_o;
    assign hs   = (state == OUT) & bus.out_ready_i;
    assign done = (state == RES) && (k == KW'(NCH - 1));

    assign bus.in_ready_o  = state == ACC;
    assign bus.out_valid_o = state == OUT;
    assign bus.out_data_o  = res[AW-1:0];
    assign bus.err_o       = err;

    csa_compress_4to2 #(.AW(AW)) u_cmp (
        .a  (acc_s),
        .b  (acc_c),
        .c  (AW'(bus.sum_i)),
        .d  (AW'(bus.cout_i)),
        .s  (cmp_s),
        .cy (cmp_c)
    );

    // Padding to whole chunks lets the last chunk read zeros above AW-1.
    assign acc_s_p = PW'(acc_s);
    assign acc_c_p = PW'(acc_c);

    // Current chunk of acc_s + acc_c plus the carry rippled from the previous chunk.
    always_comb begin
        ch_sum = {1'b0, acc_s_p[int'(k)*CHUNK +: CHUNK]} + {1'b0, acc_c_p[int'(k)*CHUNK +: CHUNK]} + (CHUNK+1)'(rc);
    end

    // Next state: a last (or forced-last) beat starts resolve, NCH chunks later the result is offered.
    always_comb begin
        state_nx = state;
        state_nx = state == ACC ? ((fire && (bus.last_i || force_last)) ? RES : ACC)
                 : state == RES ? (done ? OUT : RES)
                 : (bus.out_ready_i ? ACC : OUT);
    end

    // State, carry-save accumulators, chunk index, ripple carry and result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACC;
            acc_s <= '0;
            acc_c <= '0;
            k     <= '0;
            rc    <= 1'b0;
            res   <= '0;
        end else begin
            state <= state_nx;
            if (fire) begin
                acc_s <= cmp_s;
                acc_c <= cmp_c;
            end
            if (state == RES) begin
                res[int'(k)*CHUNK +: CHUNK] <= ch_sum[CHUNK-1:0];
                rc <= ch_sum[CHUNK];
                k  <= k + 1'b1;
            end else begin
                rc <= 1'b0;
                k  <= '0;
            end
            if (hs) begin
                acc_s <= '0;
                acc_c <= '0;
            end
        end
    end

`ifdef CSA_RES_BEATCHK_EN
    localparam int CW = MAXB > 1 ? $clog2(MAXB) : 1;
    logic [CW-1:0] cnt;
    assign force_last = cnt == CW'(MAXB - 1);

    // Beat counter; the MAXB-th beat without last is forced to end the transaction and flags err.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            err <= 1'b0;
        end else if (hs) begin
            cnt <= '0;
            err <= 1'b0;
        end else if (fire) begin
            cnt <= cnt + 1'b1;
            if (force_last && !bus.last_i) err <= 1'b1;
        end
    end
`else
    assign force_last = 1'b0;
    assign err        = 1'b0;
`endif
endmodule

// File: tb/tb_csa_resolve_acc.sv
// tb_csa_resolve_acc: table vectors, corner sequences and random streams against an arithmetic sum model
module tb_csa_resolve_acc;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;

    csa_resolve_acc_if #(.IW(13), .AW(18)) bus ();

    csa_resolve_acc dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          n;
        logic [12:0] s;
        logic [12:0] c;
        logic [17:0] exp_d;
    } vec_t;

    vec_t tab[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp_v);
        end
    endtask

    task automatic junk_drive(input bit junk);
        if (junk) begin
            bus.in_valid_i = 1'($urandom_range(0, 1));
            bus.sum_i      = 13'($urandom_range(0, 8191));
            bus.cout_i     = 13'($urandom_range(0, 8191));
            bus.last_i     = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic beat(input logic [12:0] s, input logic [12:0] c, input logic l, input int gap);
        int t = 0;
        bus.in_valid_i = 1'b0;
        repeat (gap) @(negedge clk);
        while (!bus.in_ready_o && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk("beat_ready_timeout", 32'(t), 32'd0);
        bus.in_valid_i = 1'b1;
        bus.sum_i      = s;
        bus.cout_i     = c;
        bus.last_i     = l;
        @(negedge clk);
        bus.in_valid_i = 1'b0;
        bus.last_i     = 1'b0;
    endtask

    task automatic get_result(input string nm, input logic [17:0] exp_d, input logic exp_e, input int hold, input bit junk);
        int t = 0;
        while (!bus.out_valid_o && t < 40) begin
            junk_drive(junk);
            @(negedge clk);
            t++;
        end
        if (!bus.out_valid_o) begin
            chk({nm, "_valid_timeout"}, 32'(t), 32'd3);
            bus.in_valid_i = 1'b0;
            return;
        end
        chk({nm, "_latency"}, 32'(t), 32'd3);
        chk({nm, "_data"}, 32'(bus.out_data_o), 32'(exp_d));
        chk({nm, "_err"}, 32'(bus.err_o), 32'(exp_e));
        repeat (hold) begin
            junk_drive(junk);
            bus.out_ready_i = 1'b0;
            @(negedge clk);
            chk({nm, "_hold_data"}, 32'(bus.out_data_o), 32'(exp_d));
            chk({nm, "_hold_valid"}, 32'(bus.out_valid_o), 32'd1);
            chk({nm, "_hold_in_ready"}, 32'(bus.in_ready_o), 32'd0);
        end
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b1;
        @(negedge clk);
        bus.out_ready_i = 1'b0;
        chk({nm, "_in_ready_after_hs"}, 32'(bus.in_ready_o), 32'd1);
        chk({nm, "_valid_after_hs"}, 32'(bus.out_valid_o), 32'd0);
    endtask

    initial begin
        int n;
        int gap;
        logic [12:0] s;
        logic [12:0] c;
        longint total;
        tab[0] = '{1,  13'h1FFF, 13'h0001, 18'h02000};
        tab[1] = '{2,  13'h1FFF, 13'h0001, 18'h04000};
        tab[2] = '{16, 13'h1FFF, 13'h1FFF, 18'h3FFE0};
        tab[3] = '{3,  13'h1000, 13'h0800, 18'h04800};
        tab[4] = '{1,  13'h0003, 13'h0004, 18'h00007};
        tab[5] = '{1,  13'h0000, 13'h0000, 18'h00000};
        bus.in_valid_i  = 1'b0;
        bus.sum_i       = '0;
        bus.cout_i      = '0;
        bus.last_i      = 1'b0;
        bus.out_ready_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready_o), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid_o), 32'd0);
        chk("rst_out_data", 32'(bus.out_data_o), 32'd0);
        chk("rst_err", 32'(bus.err_o), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            for (int b = 0; b < tab[i].n; b++) beat(tab[i].s, tab[i].c, b == tab[i].n - 1, 0);
            get_result($sformatf("vec%0d", i), tab[i].exp_d, 1'b0, i == 1 ? 5 : 0, 1'b0);
        end

`ifdef CSA_RES_BEATCHK_EN
        for (int b = 0; b < 16; b++) beat(13'h0001, 13'h0000, 1'b0, 0);
        get_result("beatchk_forced", 18'h00010, 1'b1, 1, 1'b0);
        beat(13'h0002, 13'h0002, 1'b1, 0);
        get_result("beatchk_next", 18'h00004, 1'b0, 0, 1'b0);
`endif

        beat(13'h0100, 13'h0010, 1'b1, 0);
        get_result("pre_reset", 18'h00110, 1'b0, 0, 1'b0);
        for (int b = 0; b < 5; b++) beat(13'h0123, 13'h0456, b == 4, 0);
        chk("res_in_ready", 32'(bus.in_ready_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 32'(bus.out_valid_o), 32'd0);
        chk("abort_out_data", 32'(bus.out_data_o), 32'd0);
        chk("abort_in_ready", 32'(bus.in_ready_o), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        beat(13'h0003, 13'h0004, 1'b1, 0);
        get_result("after_abort", 18'h00007, 1'b0, 0, 1'b0);

        for (int tr = 0; tr < 40; tr++) begin
            n = $urandom_range(1, 16);
            total = 0;
            for (int b = 0; b < n; b++) begin
                s = 13'($urandom_range(0, 8191));
                c = 13'($urandom_range(0, 8191));
                gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
                total += longint'(s) + longint'(c);
                beat(s, c, b == n - 1, gap);
            end
            get_result($sformatf("rnd%0d", tr), 18'(total % (64'd1 << 18)), 1'b0, $urandom_range(0, 3), 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
